reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter DCLO_CLK, default 24, DCLO assertion length in clk cycles (>=1).
REQ-002 SHALL have parameter ACLO_CLK, default 240, ACLO hold after DCLO release, in clk cycles (>=1).
REQ-003 SHALL have parameter PFAIL_CLK, default 16, power-fail lead (ACLO before DCLO) for a soft request, in clk cycles (>=1).
REQ-004 SHALL have parameter N, default 3, number of staged release channels (>=1).
REQ-005 SHALL have parameter STEP_CLK, default 8, spacing between channel releases, in clk cycles (>=1).
REQ-006 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-007 SHALL have parameter DEBOUNCE_CLK, default 1000, button stability window; used only under REQ-031.
REQ-008 clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 button  input  1  asynchronous soft reset request, active high.
REQ-011 plock  input  1  asynchronous hard reset request (PLL unlocked / system not ready), active high.
REQ-012 dclo  output  1  DC-low to CPU, active high, registered.
REQ-013 aclo  output  1  AC-low to CPU, active high, registered.
REQ-014 rel  output  N  per-domain release; bit k high = domain k out of reset, registered.
REQ-015 ready  output  1  high only in state RUN, registered.

Function
REQ-016 button and plock SHALL each pass through SYNC_STAGES flip-flops; sb/sp denote the last-stage outputs (sb after REQ-031 filter).
REQ-017 States SHALL be DCLO, ACLO, STAGE, RUN, PFAIL; one shared counter sized $clog2 of the largest count + 1.
REQ-018 DCLO: dclo=1, aclo=1, rel=0; counter cleared every cycle sb|sp=1; otherwise increments; after DCLO_CLK consecutive request-free cycles -> ACLO, counter 0.
REQ-019 ACLO: dclo=0, aclo=1, rel=0; after ACLO_CLK cycles -> STAGE, counter 0.
REQ-020 STAGE: dclo=0, aclo=0; every STEP_CLK cycles rel <= {rel[N-2:0],1}; cycle after rel becomes all ones -> RUN, ready=1.
REQ-021 RUN: dclo=0, aclo=0, rel all ones, ready=1; sp=1 -> DCLO next cycle; else sb=1 -> PFAIL next cycle.
REQ-022 PFAIL: aclo=1, dclo=0, rel=0, ready=0; after PFAIL_CLK cycles -> DCLO; sb deassertion ignored (sequence completes).
REQ-023 sp=1 in any state SHALL force DCLO next cycle; sp has priority over sb when both are high.
REQ-024 sb=1 in ACLO or STAGE SHALL go directly to DCLO (no power-fail lead); sb=1 in DCLO holds DCLO per REQ-018.
REQ-025 Request held indefinitely SHALL hold DCLO indefinitely; sequence restarts from count 0 at release.
REQ-026 Counter SHALL never wrap; terminal compares use exact equality to parameter-1.
REQ-027 N=1 SHALL be legal: STAGE lasts STEP_CLK cycles then one cycle to RUN.

Reset
REQ-028 reset=1 SHALL, next edge: state DCLO, counter 0, synchroniser and debounce registers 0, dclo=1, aclo=1, rel=0, ready=0.
REQ-029 reset mid-sequence (any state) SHALL abort and restart per REQ-028; no partial release retained.
REQ-030 After reset deasserts with no request, dclo SHALL fall exactly DCLO_CLK cycles later.

Configuration
REQ-031 Macro RESET_SEQ_DEBOUNCE_EN defined: synchronised button SHALL change filtered level sb only after DEBOUNCE_CLK consecutive equal samples; undefined: sb equals synchroniser output, no debounce logic; plock never debounced.

Verification
REQ-032 Defaults, reset 1->0, inputs low -> dclo falls 24 cycles later, aclo falls 240 after that, rel 001/011/111 at 8-cycle steps, ready 1 one cycle after 111.
REQ-033 In RUN, button pulse -> aclo=1, rel=0 within SYNC_STAGES+1 cycles, dclo=1 exactly 16 cycles later, full sequence replays.
REQ-034 In RUN, button and plock asserted same cycle -> dclo=1 with no PFAIL phase (aclo and dclo rise same cycle).
REQ-035 plock held 500 cycles during STAGE (rel=011) -> rel=0, dclo=1 for 500+24 cycles after sync, then normal sequence.
REQ-036 reset asserted during PFAIL count 5 -> all outputs to reset values next edge; after release dclo falls after 24 cycles.
REQ-037 With RESET_SEQ_DEBOUNCE_EN, DEBOUNCE_CLK=10: 9-cycle button glitch in RUN -> no change; 10-cycle pulse -> PFAIL entered.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-on / soft reset sequencer: DCLO, ACLO, staged domain release, power-fail lead
// Optional button debounce filter enabled by defining RESET_SEQ_DEBOUNCE_EN.
module reset_sequencer #(
  parameter int DCLO_CLK     = 24,
  parameter int ACLO_CLK     = 240,
  parameter int PFAIL_CLK    = 16,
  parameter int N            = 3,
  parameter int STEP_CLK     = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CLK = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         button,
  input  logic         plock,
  output logic         dclo,
  output logic         aclo,
  output logic [N-1:0] rel,
  output logic         ready
);

  localparam logic [2:0] S_DCLO  = 3'd0;
  localparam logic [2:0] S_ACLO  = 3'd1;
  localparam logic [2:0] S_STAGE = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PFAIL = 3'd4;

  localparam int MAX_A = (DCLO_CLK > ACLO_CLK) ? DCLO_CLK : ACLO_CLK;
  localparam int MAX_B = (PFAIL_CLK > STEP_CLK) ? PFAIL_CLK : STEP_CLK;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXC + 1);

  if (DCLO_CLK < 1 || ACLO_CLK < 1 || PFAIL_CLK < 1 || N < 1 || STEP_CLK < 1 ||
      SYNC_STAGES < 2 || DEBOUNCE_CLK < 1) begin : g_param_check
    $error("reset_sequencer: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [SYNC_STAGES-1:0] sync_p_q;
  logic                   sb_raw;
  logic                   sb;
  logic                   sp;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_b_q <= '0;
      sync_p_q <= '0;
    end else begin
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], button};
      sync_p_q <= {sync_p_q[SYNC_STAGES-2:0], plock};
    end
  end

  assign sb_raw = sync_b_q[SYNC_STAGES-1];
  assign sp     = sync_p_q[SYNC_STAGES-1];

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CLK + 1);

  logic          sb_q;
  logic [DW-1:0] deb_cnt_q;

  // Filtered level only follows the synchronised button after DEBOUNCE_CLK differing samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q      <= 1'b0;
      deb_cnt_q <= '0;
    end else if (sb_raw == sb_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DW'(DEBOUNCE_CLK - 1)) begin
      sb_q      <= sb_raw;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DW'(1);
    end
  end

  assign sb = sb_q;
`else
  assign sb = sb_raw;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rel_q, rel_d;
  logic          dclo_q, aclo_q, ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    rel_d   = rel_q;
    case (state_q)
      S_DCLO: begin
        rel_d = '0;
        if (sb) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DCLO_CLK - 1)) begin
          state_d = S_ACLO;
          cnt_d   = '0;
        end
      end
      S_ACLO: begin
        if (sb) begin
          state_d = S_DCLO;
          cnt_d   = '0;
        end else if (cnt_q == CW'(ACLO_CLK - 1)) begin
          state_d = S_STAGE;
          cnt_d   = '0;
        end
      end
      S_STAGE: begin
        if (sb) begin
          state_d = S_DCLO;
          cnt_d   = '0;
          rel_d   = '0;
        end else if (&rel_q) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STEP_CLK - 1)) begin
          rel_d = (rel_q << 1) | N'(1);
          cnt_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (sb) begin
          state_d = S_PFAIL;
          rel_d   = '0;
        end
      end
      S_PFAIL: begin
        rel_d = '0;
        if (cnt_q == CW'(PFAIL_CLK - 1)) begin
          state_d = S_DCLO;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_DCLO;
        cnt_d   = '0;
        rel_d   = '0;
      end
    endcase
    // A hard request overrides everything, including a pending soft request.
    if (sp) begin
      state_d = S_DCLO;
      cnt_d   = '0;
      rel_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DCLO;
      cnt_q   <= '0;
      rel_q   <= '0;
      dclo_q  <= 1'b1;
      aclo_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      dclo_q  <= (state_d == S_DCLO);
      aclo_q  <= (state_d == S_DCLO) || (state_d == S_ACLO) || (state_d == S_PFAIL);
      ready_q <= (state_d == S_RUN);
    end
  end

  assign dclo  = dclo_q;
  assign aclo  = aclo_q;
  assign rel   = rel_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
// Button-timing tests assume the default build; RESET_SEQ_DEBOUNCE_EN swaps in the debounce test.
module tb_reset_sequencer;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         button;
  logic         plock;
  logic         dclo;
  logic         aclo;
  logic [N-1:0] rel;
  logic         ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .DCLO_CLK    (24),
    .ACLO_CLK    (240),
    .PFAIL_CLK   (16),
    .N           (N),
    .STEP_CLK    (8),
    .SYNC_STAGES (2),
    .DEBOUNCE_CLK(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .plock (plock),
    .dclo  (dclo),
    .aclo  (aclo),
    .rel   (rel),
    .ready (ready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic d, input logic a,
                            input logic [N-1:0] r, input logic rd);
    check_val({tag, ".dclo"}, 32'(dclo), 32'(d));
    check_val({tag, ".aclo"}, 32'(aclo), 32'(a));
    check_val({tag, ".rel"}, 32'(rel), 32'(r));
    check_val({tag, ".ready"}, 32'(ready), 32'(rd));
  endtask

  // Call right after the edge that put the sequencer into DCLO with count 0 and no request pending.
  task automatic check_sequence(input string tag);
    step(23);  check_outs({tag, " dclo_last"}, 1'b1, 1'b1, 3'b000, 1'b0);
    step(1);   check_outs({tag, " dclo_fall"}, 1'b0, 1'b1, 3'b000, 1'b0);
    step(239); check_outs({tag, " aclo_last"}, 1'b0, 1'b1, 3'b000, 1'b0);
    step(1);   check_outs({tag, " aclo_fall"}, 1'b0, 1'b0, 3'b000, 1'b0);
    step(7);   check_outs({tag, " rel0_last"}, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1);   check_outs({tag, " rel001"},    1'b0, 1'b0, 3'b001, 1'b0);
    step(8);   check_outs({tag, " rel011"},    1'b0, 1'b0, 3'b011, 1'b0);
    step(8);   check_outs({tag, " rel111"},    1'b0, 1'b0, 3'b111, 1'b0);
    step(1);   check_outs({tag, " ready"},     1'b0, 1'b0, 3'b111, 1'b1);
  endtask

  initial begin
    reset  = 1'b1;
    button = 1'b0;
    plock  = 1'b0;
    step(3);
    check_outs("reset", 1'b1, 1'b1, 3'b000, 1'b0);
    reset = 1'b0;
    check_sequence("por");

    // Button and plock together: straight to DCLO, no power-fail lead.
    button = 1'b1;
    plock  = 1'b1;
    step(1);
    button = 1'b0;
    plock  = 1'b0;
    step(1);  check_outs("both pre", 1'b0, 1'b0, 3'b111, 1'b1);
    step(1);  check_outs("both hit", 1'b1, 1'b1, 3'b000, 1'b0);
    check_sequence("both");

    // Reach STAGE with rel=011, then hold plock for 500 cycles.
    plock = 1'b1;
    step(1);
    plock = 1'b0;
    step(2);   check_outs("pl hit", 1'b1, 1'b1, 3'b000, 1'b0);
    step(280); check_outs("pl stage", 1'b0, 1'b0, 3'b011, 1'b0);
    plock = 1'b1;
    step(1);
    step(1);   check_outs("hold pre", 1'b0, 1'b0, 3'b011, 1'b0);
    step(1);   check_outs("hold hit", 1'b1, 1'b1, 3'b000, 1'b0);
    step(298); check_outs("hold mid", 1'b1, 1'b1, 3'b000, 1'b0);
    step(199);
    plock = 1'b0;
    step(2);   check_outs("hold end", 1'b1, 1'b1, 3'b000, 1'b0);
    check_sequence("hold");

`ifndef RESET_SEQ_DEBOUNCE_EN
    // Button pulse in RUN: power-fail lead then full replay.
    button = 1'b1;
    step(1);  check_outs("pf e0", 1'b0, 1'b0, 3'b111, 1'b1);
    button = 1'b0;
    step(1);  check_outs("pf e1", 1'b0, 1'b0, 3'b111, 1'b1);
    step(1);  check_outs("pf aclo", 1'b0, 1'b1, 3'b000, 1'b0);
    step(15); check_outs("pf last", 1'b0, 1'b1, 3'b000, 1'b0);
    step(1);  check_outs("pf dclo", 1'b1, 1'b1, 3'b000, 1'b0);
    check_sequence("pfail");

    // Reset at PFAIL count 5.
    button = 1'b1;
    step(1);
    button = 1'b0;
    step(2);
    step(5);  check_outs("rst pf", 1'b0, 1'b1, 3'b000, 1'b0);
    reset = 1'b1;
    step(1);  check_outs("rst hit", 1'b1, 1'b1, 3'b000, 1'b0);
    reset = 1'b0;
    check_sequence("rst");

    // Button during ACLO: direct DCLO without power-fail lead.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(30); check_outs("ac pre", 1'b0, 1'b1, 3'b000, 1'b0);
    button = 1'b1;
    step(1);
    button = 1'b0;
    step(1);  check_outs("ac e1", 1'b0, 1'b1, 3'b000, 1'b0);
    step(1);  check_outs("ac hit", 1'b1, 1'b1, 3'b000, 1'b0);
    check_sequence("aclo_btn");
`else
    // 9-cycle glitch is filtered, 10-cycle press enters PFAIL.
    button = 1'b1;
    step(9);
    button = 1'b0;
    step(15); check_outs("glitch", 1'b0, 1'b0, 3'b111, 1'b1);
    button = 1'b1;
    step(10);
    button = 1'b0;
    step(2);  check_outs("deb pre", 1'b0, 1'b0, 3'b111, 1'b1);
    step(1);  check_outs("deb pf", 1'b0, 1'b1, 3'b000, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
